// File: rtl/memory_address_register.sv
// Memory address register: a 4-bit address latched either from the CPU bus
// (automatic mode) or from front-panel switches on a pushbutton press
// (manual mode). The address output comes straight from the register.
//
// Load semantics: a load is a single-cycle event sampled at the rising clk
// edge. In automatic mode read_from_bus=1 loads bus. In manual mode only the
// 0->1 transition of manual_read (against its value at the previous edge)
// loads manual_switches, so a held button produces exactly one load. Reset
// wins over both load paths.
module memory_address_register (
   input  logic       clk,
   input  logic       rst,
   input  logic       read_from_bus,
   input  logic       manual_mode,
   input  logic       manual_read,
   input  logic [3:0] manual_switches,
   input  logic [3:0] bus,
   output logic [3:0] address
);

   logic [3:0] address_q;
   logic [3:0] address_d;
   logic       manual_read_q;
   logic       manual_press;

   // Button edge detect: previous sample low, current sample high.
   assign manual_press = manual_read & ~manual_read_q;

   // Next-address selection; the inactive mode's inputs are never looked at.
   always_comb begin
      address_d = address_q;
      if (manual_mode) begin
         if (manual_press) begin
            address_d = manual_switches;
         end
      end else if (read_from_bus) begin
         address_d = bus;
      end
   end

   // Button history tracks every edge, reset included, so a button held
   // across reset release or mode entry never looks like a fresh press.
   always_ff @(posedge clk) begin
      manual_read_q <= manual_read;
   end

   // Address register with synchronous reset taking priority over loads.
   always_ff @(posedge clk) begin
      if (rst) begin
         address_q <= 4'h0;
      end else begin
         address_q <= address_d;
      end
   end

   assign address = address_q;

endmodule

// File: tb/tb_memory_address_register.sv
// Bench for memory_address_register: table of directed vectors, a sweep of
// every bus value, a synchronous-reset timing check and a random phase
// checked against a small behavioural model.
module tb_memory_address_register;

   logic       clk;
   logic       rst;
   logic       read_from_bus;
   logic       manual_mode;
   logic       manual_read;
   logic [3:0] manual_switches;
   logic [3:0] bus;
   logic [3:0] address;

   int checks   = 0;
   int failures = 0;

   logic [3:0] exp_q[$];

   typedef struct {
      logic       rst;
      logic       rfb;
      logic       mm;
      logic       mr;
      logic [3:0] sw;
      logic [3:0] bus;
      logic [3:0] exp;
   } vec_t;

   vec_t vecs[$];

   memory_address_register dut (
      .clk             (clk),
      .rst             (rst),
      .read_from_bus   (read_from_bus),
      .manual_mode     (manual_mode),
      .manual_read     (manual_read),
      .manual_switches (manual_switches),
      .bus             (bus),
      .address         (address)
   );

   // clock / reset
   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic vec_t mk(input logic r, input logic rfb, input logic mm,
                               input logic mr, input logic [3:0] sw,
                               input logic [3:0] b, input logic [3:0] e);
      vec_t v;
      v.rst = r; v.rfb = rfb; v.mm = mm; v.mr = mr;
      v.sw = sw; v.bus = b; v.exp = e;
      return v;
   endfunction

   task automatic check(input string name, input logic [3:0] act, input logic [3:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: address=0x%h expected=0x%h at %0t", name, act, exp, $time);
      end
   endtask

   // driver: present inputs for one edge, record expectation, compare after edge
   task automatic apply(input vec_t v, input string name);
      rst             = v.rst;
      read_from_bus   = v.rfb;
      manual_mode     = v.mm;
      manual_read     = v.mr;
      manual_switches = v.sw;
      bus             = v.bus;
      exp_q.push_back(v.exp);
      @(posedge clk);
      #1;
      if (exp_q.size() == 0) begin
         checks++;
         failures++;
         $display("FAIL %s: scoreboard empty", name);
      end else begin
         check(name, address, exp_q.pop_front());
      end
   endtask

   initial begin
      logic [3:0] m_addr;
      logic       m_prev;
      vec_t       v;

      rst = 1'b1; read_from_bus = 1'b0; manual_mode = 1'b0; manual_read = 1'b0;
      manual_switches = 4'h0; bus = 4'h0;

      //                rst rfb mm mr  sw     bus    exp
      vecs.push_back(mk(1, 0, 0, 0, 4'h0, 4'h0, 4'h0)); // reset state
      vecs.push_back(mk(0, 1, 0, 0, 4'h0, 4'hB, 4'hB)); // preload 0xB
      vecs.push_back(mk(1, 1, 0, 0, 4'h0, 4'h7, 4'h0)); // reset beats bus load
      vecs.push_back(mk(0, 1, 0, 0, 4'h0, 4'h5, 4'h5)); // bus load
      vecs.push_back(mk(0, 0, 0, 0, 4'h0, 4'hA, 4'h5)); // hold
      vecs.push_back(mk(0, 0, 0, 0, 4'h0, 4'hA, 4'h5));
      vecs.push_back(mk(0, 0, 0, 0, 4'h0, 4'hA, 4'h5));
      vecs.push_back(mk(0, 0, 1, 0, 4'h9, 4'h0, 4'h5)); // manual, button low
      vecs.push_back(mk(0, 0, 1, 1, 4'h9, 4'h0, 4'h9)); // press loads 0x9
      vecs.push_back(mk(0, 0, 1, 1, 4'h3, 4'h0, 4'h9)); // held: no reload
      vecs.push_back(mk(0, 0, 1, 1, 4'h3, 4'h0, 4'h9));
      vecs.push_back(mk(0, 0, 1, 1, 4'h3, 4'h0, 4'h9));
      vecs.push_back(mk(0, 0, 1, 0, 4'h3, 4'h0, 4'h9)); // release
      vecs.push_back(mk(0, 0, 1, 1, 4'h3, 4'h0, 4'h3)); // press again
      vecs.push_back(mk(0, 1, 1, 1, 4'h3, 4'hE, 4'h3)); // bus ignored in manual
      vecs.push_back(mk(0, 1, 1, 0, 4'h3, 4'hE, 4'h3));
      vecs.push_back(mk(0, 0, 0, 1, 4'h6, 4'h0, 4'h3)); // switches ignored in auto
      vecs.push_back(mk(0, 0, 0, 0, 4'h6, 4'h0, 4'h3));
      vecs.push_back(mk(0, 0, 0, 1, 4'h6, 4'h0, 4'h3));
      vecs.push_back(mk(0, 0, 0, 1, 4'hC, 4'h0, 4'h3)); // button held in auto
      vecs.push_back(mk(0, 0, 1, 1, 4'hC, 4'h0, 4'h3)); // enter manual held: no load
      vecs.push_back(mk(0, 0, 1, 1, 4'hC, 4'h0, 4'h3));
      vecs.push_back(mk(0, 0, 1, 0, 4'hC, 4'h0, 4'h3)); // release
      vecs.push_back(mk(0, 0, 1, 1, 4'hC, 4'h0, 4'hC)); // press loads 0xC
      vecs.push_back(mk(0, 0, 0, 0, 4'h0, 4'h1, 4'hC)); // mode change keeps value
      vecs.push_back(mk(1, 0, 1, 1, 4'h4, 4'h0, 4'h0)); // reset with button held
      vecs.push_back(mk(0, 0, 1, 1, 4'h4, 4'h0, 4'h0)); // held across release: no load
      vecs.push_back(mk(0, 0, 1, 0, 4'h4, 4'h0, 4'h0));
      vecs.push_back(mk(0, 0, 1, 1, 4'h4, 4'h0, 4'h4)); // fresh press
      vecs.push_back(mk(0, 0, 1, 0, 4'h4, 4'h0, 4'h4));
      vecs.push_back(mk(1, 1, 1, 1, 4'h8, 4'h9, 4'h0)); // reset beats manual press
      vecs.push_back(mk(0, 0, 1, 0, 4'h8, 4'h0, 4'h0)); // normal operation resumes
      vecs.push_back(mk(0, 1, 0, 0, 4'h8, 4'hD, 4'hD)); // mode change effective same edge
      vecs.push_back(mk(0, 1, 1, 1, 4'h2, 4'h7, 4'h2)); // into manual with fresh press

      foreach (vecs[i]) apply(vecs[i], $sformatf("vec%0d", i));

      // every bus value on consecutive edges
      for (int i = 0; i < 16; i++) begin
         apply(mk(0, 1, 0, 0, 4'h0, 4'(i), 4'(i)), $sformatf("sweep%0d", i));
      end

      // reset is sampled only at the edge: mid-cycle assert must not disturb address
      rst = 1'b1;
      read_from_bus = 1'b0;
      #3;
      check("rst_no_async", address, 4'hF);
      @(posedge clk);
      #1;
      check("rst_at_edge", address, 4'h0);

      // random phase against a behavioural model
      apply(mk(1, 0, 0, 0, 4'h0, 4'h0, 4'h0), "rand_reset");
      m_addr = 4'h0;
      m_prev = 1'b0;
      for (int i = 0; i < 300; i++) begin
         v.rst = ($urandom_range(0, 19) == 0);
         v.rfb = $urandom_range(0, 1);
         v.mm  = $urandom_range(0, 1);
         v.mr  = ($urandom_range(0, 2) != 0);
         v.sw  = 4'($urandom_range(0, 15));
         v.bus = 4'($urandom_range(0, 15));
         if (v.rst) m_addr = 4'h0;
         else if (v.mm) begin
            if (v.mr && !m_prev) m_addr = v.sw;
         end else if (v.rfb) m_addr = v.bus;
         m_prev = v.mr;
         v.exp = m_addr;
         apply(v, $sformatf("rand%0d", i));
      end

      if (exp_q.size() != 0) begin
         checks++;
         failures++;
         $display("FAIL scoreboard_drain: %0d entries left, expected 0", exp_q.size());
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
